// File: rtl/btn_pkg.sv
// Shared types and constants for the DE2 push-button conditioning logic.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 5000000;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_SHOOT = 2;
    localparam int unsigned BTN_STOP  = 3;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button 2-flop synchroniser, debounce FSM and press-edge pulse.
// Auto-repeat while held is built only when BTN_AUTOREPEAT_EN is defined.
module button_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic pulse_o,
    output logic level_o
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]   sync_q;
    logic         sample;
    btn_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         pulse_q, pulse_d;
    logic         level_q, level_d;

    assign sample  = sync_q[1];
    assign pulse_o = pulse_q;
    assign level_o = level_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_armed_q, rep_armed_d;
    logic          rep_hit;

    assign rep_hit = rep_armed_q ? (rep_cnt_q == REP_PERIOD_LAST)
                                 : (rep_cnt_q == REP_DELAY_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], ~key_ni};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sample) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sample) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sample) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sample) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);

`ifdef BTN_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        // Only a fresh accept restarts the repeat schedule; a bounced release keeps it.
        if (state_q == PRESS_WAIT && state_d == HELD) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (state_q == HELD && state_d == HELD) begin
            if (rep_hit) begin
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
                pulse_d     = ~pulse_q;
            end else if (rep_cnt_q != '1) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Conditions the active-low DE2 KEY buttons into debounced levels and press pulses.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module button_pulse_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] key_n,
    output logic [NUM_BTN-1:0] pulse,
    output logic [NUM_BTN-1:0] level
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_debounce (
            .clk_i  (clock),
            .rst_ni (reset),
            .key_ni (key_n[i]),
            .pulse_o(pulse[i]),
            .level_o(level[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with short debounce/repeat settings.
module tb_button_pulse_conditioner;
    import btn_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] pulse;
    logic [3:0] level;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         e;
    logic [3:0] ph [64];
    logic [3:0] lh [64];

    always #5 clock = ~clock;

    button_pulse_conditioner #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_n(key_n),
        .pulse(pulse),
        .level(level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply kn for edge e, record outputs in the following low phase.
    task automatic drive(input logic [3:0] kn);
        key_n = kn;
        @(posedge clock);
        @(negedge clock);
        if (e < 64) begin
            ph[e] = pulse;
            lh[e] = level;
        end
        e++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        key_n = '1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 64; i++) begin
            ph[i] = '0;
            lh[i] = '0;
        end
        e = 0;
    endtask

    function automatic int count_ones(input bit use_level, input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += use_level ? int'(lh[i][b]) : int'(ph[i][b]);
        return n;
    endfunction

    initial begin
        reset = 1'b0;
        key_n = '1;
        e     = 0;
        repeat (2) @(negedge clock);
        check("reset_pulse", 32'(pulse), 32'h0);
        check("reset_level", 32'(level), 32'h0);

        // Clean press then release on left
        do_reset();
        for (int i = 0; i < 40; i++) drive(i < 20 ? 4'b1110 : 4'b1111);
        check("press_p5",     32'(ph[5][BTN_LEFT]), 32'h0);
        check("press_p6",     32'(ph[6]), 32'h1);
        check("press_p7",     32'(ph[7]), 32'h0);
        check("press_l5",     32'(lh[5]), 32'h0);
        check("press_l6",     32'(lh[6]), 32'h1);
        check("press_npulse", 32'(count_ones(1'b0, BTN_LEFT, 0, 39)), 32'd1);
        check("rel_l25",      32'(lh[25]), 32'h1);
        check("rel_l26",      32'(lh[26]), 32'h0);

        // Bouncing right button
        do_reset();
        for (int i = 0; i < 40; i++)
            drive({2'b11, ((i >= 12) || ((i / 2) % 2 == 0)) ? 1'b0 : 1'b1, 1'b1});
        check("bounce_p17",     32'(ph[17]), 32'h0);
        check("bounce_p18",     32'(ph[18]), 32'h2);
        check("bounce_l17",     32'(lh[17]), 32'h0);
        check("bounce_npulse",  32'(count_ones(1'b0, BTN_RIGHT, 0, 39)), 32'd1);

        // Simultaneous press of all buttons
        do_reset();
        for (int i = 0; i < 20; i++) drive(4'b0000);
        check("simul_p5", 32'(ph[5]), 32'h0);
        check("simul_p6", 32'(ph[6]), 32'hF);
        check("simul_p7", 32'(ph[7]), 32'h0);
        check("simul_l6", 32'(lh[6]), 32'hF);

        // Reset during PRESS_WAIT with key still held
        do_reset();
        for (int i = 0; i < 4; i++) drive(4'b1110);
        reset = 1'b0;
        #1;
        check("midrst_pulse", 32'(pulse), 32'h0);
        check("midrst_level", 32'(level), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        e = 0;
        for (int i = 0; i < 12; i++) drive(4'b1110);
        check("midrst_p5",     32'(ph[5]), 32'h0);
        check("midrst_p6",     32'(ph[6]), 32'h1);
        check("midrst_npulse", 32'(count_ones(1'b0, BTN_LEFT, 0, 11)), 32'd1);

        // Long hold on shoot
        do_reset();
        for (int i = 0; i < 40; i++) drive(i < 30 ? 4'b1011 : 4'b1111);
        check("hold_p6", 32'(ph[6]), 32'h4);
`ifdef BTN_AUTOREPEAT_EN
        check("rep_p15",    32'(ph[15]), 32'h0);
        check("rep_p16",    32'(ph[16]), 32'h4);
        check("rep_p17",    32'(ph[17]), 32'h0);
        check("rep_p19",    32'(ph[19]), 32'h4);
        check("rep_p22",    32'(ph[22]), 32'h4);
        check("rep_npulse", 32'(count_ones(1'b0, BTN_SHOOT, 0, 29)), 32'd6);
`else
        check("norep_p16",    32'(ph[16]), 32'h0);
        check("norep_npulse", 32'(count_ones(1'b0, BTN_SHOOT, 0, 39)), 32'd1);
`endif

        // Short release glitch on stop while held
        do_reset();
        for (int i = 0; i < 30; i++) drive((i == 10 || i == 11) ? 4'b1111 : 4'b0111);
        check("glitch_p6",     32'(ph[6]), 32'h8);
        check("glitch_l5",     32'(lh[5][BTN_STOP]), 32'h0);
        check("glitch_level",  32'(count_ones(1'b1, BTN_STOP, 6, 29)), 32'd24);
        check("glitch_npulse", 32'(count_ones(1'b0, BTN_STOP, 0, 18)), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
